key_exp_word: RTL and testbench
===============================

Name: key_exp_word

Overview:
- Word-generation stage of the AES key schedule. Sits directly downstream of the key-expansion loop counter (for_mod).
- Each counter step, it consumes the counter's word index i and i mod Nk and produces expanded word w[i]. It packs words into 128-bit round keys for the cipher datapath.
- S-box lookups use an external shared 4-byte S-box (combinational, same-cycle).

Parameters:
- KEY_W, 256, width of key_in; words taken MSB-first.
- IDX_W, 6, width of word index (max 59).

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  synchronous active-high reset.
- conf_in  in  2  key size: 0=AES-128 (Nk=4, 44 words), 1=AES-192 (Nk=6, 52 words), 2=AES-256 (Nk=8, 60 words), 3=treated as 0.
- load_in  in  1  one-cycle pulse; captures key_in and conf_in.
- key_in  in  256  cipher key; w0=key_in[255:224], w1=[223:192], and so on.
- step_in  in  1  counter advance; i_in/imodk_in/last_in are valid this cycle.
- i_in  in  6  current word index, Nk..4*Nr+3.
- imodk_in  in  3  i mod Nk.
- last_in  in  1  final index of the schedule.
- sbox_word_out  out  32  word sent to external S-box.
- sbox_word_in  in  32  SubWord(sbox_word_out), same cycle.
- word_out  out  32  w[i].
- word_idx_out  out  6  index of word_out.
- word_valid_out  out  1  word_out valid, one cycle.
- rk_out  out  128  round key, w[4r]..w[4r+3], w[4r] in MSBs.
- rk_idx_out  out  4  round number r.
- rk_valid_out  out  1  rk_out valid, one cycle.
- done_out  out  1  pulses with the word produced for last_in.
- err_out  out  1  sticky error, cleared by load_in or reset.

Behaviour:
- Reset: all outputs 0, window cleared, rcon=8'h01, state IDLE.
- States: IDLE -> (load_in) -> RUN -> (word for last_in emitted) -> IDLE.
- load_in in any state, including mid-RUN, restarts:
  - window <= the Nk key words;
  - expected index <= Nk;
  - rcon <= 8'h01;
  - err cleared.
- Window: shift register of the last Nk words. Oldest word = w[i-Nk], newest = w[i-1].
- Word computation on step_in in RUN, with t = w[i-1]:
  - imodk_in==0: sbox_word_out = RotWord(t) (left byte rotate); temp = sbox_word_in ^ {rcon,24'h0}; after use, rcon <= xtime(rcon) (shift left 1, XOR 8'h1b if bit7 was set).
  - Nk==8 and imodk_in==4: sbox_word_out = t; temp = sbox_word_in.
  - Otherwise: temp = t; sbox_word_out = t (don't-care).
  - w[i] = w[i-Nk] ^ temp.
- Latency: word_out/word_idx_out/word_valid_out registered, one cycle after step_in. The window shifts on the same edge. Back-to-back step_in every cycle is supported.
- Round-key packer:
  - Collects 4 words; issues rk_valid_out on the cycle the 4th word of round r is registered.
  - On load (cycle after load_in): rk0 emitted for all sizes.
  - Nk=6: w4,w5 are preloaded into the packer.
  - Nk=8: rk1 is emitted the following cycle.
  - Round indices are monotonic, 0..Nr.
- Checks (set err_out; offending step is ignored, no output produced):
  - step_in in IDLE;
  - i_in != expected index;
  - imodk_in != expected index mod Nk.
- done_out: asserted with word_valid_out of the word whose step had last_in=1. Returns to IDLE.
- last_in at an index other than 4*Nr+3 sets err_out and still terminates.
- step_in coincident with load_in: load wins, step ignored, no error.
- Reset mid-RUN: immediate return to reset values on the next edge.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, 40 steps:
  - w4=a0fafe17, w43=b6630ca6;
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done_out with idx 43; err_out=0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 46 steps:
  - w6=fe0c91f7, w51=01002202;
  - 13 round keys, idx 0..12.
- AES-256, key 603deb10...0914dff4 (FIPS-197 A.3), 52 steps:
  - w8=9ba35411, w12=a8b09c1a (SubWord-only path), w59=706c631e.
- Step with i_in=5 when 4 expected -> err_out=1, no word_valid_out; subsequent load_in clears err_out.
- load_in mid-RUN at i=20 (AES-128) -> next word emitted is w4 of the new key; rcon restarts at 01.
- rst_in at step 10 -> all outputs 0 next cycle; step_in afterwards -> err_out=1 (IDLE).

Source files
------------

// File: rtl/key_exp_word.sv
// Word-generation stage of the AES key schedule. Each counter step produces w[i]
// from a sliding window of the last Nk words, and packs the words into round keys.
module key_exp_word #(
  parameter int KEY_W = 256,
  parameter int IDX_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [1:0]       conf_in,
  input  logic             load_in,
  input  logic [KEY_W-1:0] key_in,
  input  logic             step_in,
  input  logic [IDX_W-1:0] i_in,
  input  logic [2:0]       imodk_in,
  input  logic             last_in,
  output logic [31:0]      sbox_word_out,
  input  logic [31:0]      sbox_word_in,
  output logic [31:0]      word_out,
  output logic [IDX_W-1:0] word_idx_out,
  output logic             word_valid_out,
  output logic [127:0]     rk_out,
  output logic [3:0]       rk_idx_out,
  output logic             rk_valid_out,
  output logic             done_out,
  output logic             err_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       nk_m1;       // Nk-1: 3, 5 or 7
  logic [31:0]      win [8];     // win[0] = w[i-1], win[nk_m1] = w[i-Nk]
  logic [31:0]      rk_buf [3];  // words 0..2 of the round key being assembled
  logic [IDX_W-1:0] exp_idx;
  logic [2:0]       exp_mod;
  logic [7:0]       rcon;
  logic             rk1_pend;

  logic [31:0]      kw [8];
  logic [31:0]      ld_win [8];
  logic [2:0]       ld_nk_m1;
  logic [31:0]      t;
  logic [31:0]      temp;
  logic [31:0]      new_word;
  logic [IDX_W-1:0] last_idx;
  logic             rot_sel;
  logic             sub_sel;
  logic             step_ok;
  logic             step_bad;

  always_comb begin
    // NOTE: every variable gets a value before any conditional, so no latch can be inferred.
    for (int j = 0; j < 8; j++) begin
      kw[j] = key_in[KEY_W-1-32*j -: 32];
    end
    case (conf_in)
      2'd1:    ld_nk_m1 = 3'd5;
      2'd2:    ld_nk_m1 = 3'd7;
      default: ld_nk_m1 = 3'd3;
    endcase
    // Load the newest key word into win[0] so the window reads back in schedule order.
    for (int k = 0; k < 8; k++) begin
      ld_win[k] = '0;
      if (3'(k) <= ld_nk_m1) ld_win[k] = kw[ld_nk_m1 - 3'(k)];
    end
  end

  assign t        = win[0];
  assign rot_sel  = (imodk_in == 3'd0);
  assign sub_sel  = (nk_m1 == 3'd7) && (imodk_in == 3'd4);
  assign sbox_word_out = rot_sel ? {t[23:0], t[31:24]} : t;
  assign temp     = rot_sel ? (sbox_word_in ^ {rcon, 24'h0}) :
                    sub_sel ? sbox_word_in : t;
  assign new_word = win[nk_m1] ^ temp;
  assign last_idx = IDX_W'({nk_m1, 2'b00}) + IDX_W'(31);

  assign step_ok  = step_in && (state == RUN) && (i_in == exp_idx) && (imodk_in == exp_mod);
  assign step_bad = step_in && !step_ok;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      nk_m1          <= 3'd3;
      exp_idx        <= '0;
      exp_mod        <= '0;
      rcon           <= 8'h01;
      rk1_pend       <= 1'b0;
      // NOTE: the window and packer are small register files, so clearing them on reset is cheap and keeps sbox_word_out at 0.
      for (int k = 0; k < 8; k++) win[k] <= '0;
      for (int k = 0; k < 3; k++) rk_buf[k] <= '0;
      word_out       <= '0;
      word_idx_out   <= '0;
      word_valid_out <= 1'b0;
      rk_out         <= '0;
      rk_idx_out     <= '0;
      rk_valid_out   <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      word_valid_out <= 1'b0;
      rk_valid_out   <= 1'b0;
      done_out       <= 1'b0;
      rk1_pend       <= 1'b0;
      if (load_in) begin
        state        <= RUN;
        nk_m1        <= ld_nk_m1;
        exp_idx      <= IDX_W'(ld_nk_m1) + IDX_W'(1);
        exp_mod      <= '0;
        rcon         <= 8'h01;
        err_out      <= 1'b0;
        for (int k = 0; k < 8; k++) win[k] <= ld_win[k];
        rk_out       <= {kw[0], kw[1], kw[2], kw[3]};
        rk_idx_out   <= '0;
        rk_valid_out <= 1'b1;
        rk1_pend     <= (ld_nk_m1 == 3'd7);
        // Key words 4/5 are the head of rk1 when Nk=6; otherwise they are overwritten before use.
        rk_buf[0]    <= kw[4];
        rk_buf[1]    <= kw[5];
        rk_buf[2]    <= kw[6];
      end else begin
        if (rk1_pend) begin
          rk_out       <= {win[3], win[2], win[1], win[0]};
          rk_idx_out   <= 4'd1;
          rk_valid_out <= 1'b1;
        end
        if (step_bad) err_out <= 1'b1;
        if (step_ok) begin
          win[0] <= new_word;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          word_out       <= new_word;
          word_idx_out   <= i_in;
          word_valid_out <= 1'b1;
          exp_idx        <= exp_idx + IDX_W'(1);
          exp_mod        <= (exp_mod == nk_m1) ? 3'd0 : exp_mod + 3'd1;
          if (rot_sel) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          case (i_in[1:0])
            2'd0: rk_buf[0] <= new_word;
            2'd1: rk_buf[1] <= new_word;
            2'd2: rk_buf[2] <= new_word;
            default: begin
              rk_out       <= {rk_buf[0], rk_buf[1], rk_buf[2], new_word};
              rk_idx_out   <= i_in[IDX_W-1:2];
              rk_valid_out <= 1'b1;
            end
          endcase
          if (last_in) begin
            done_out <= 1'b1;
            state    <= IDLE;
            if (i_in != last_idx) err_out <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_key_exp_word.sv
// Bench for key_exp_word: a FIPS-197 key-schedule model predicts every word, round key,
// done and error output cycle by cycle; known-answer vectors pin the model itself.
`timescale 1ns/1ps
module tb_key_exp_word;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [1:0]   conf_in = '0;
  logic         load_in = 1'b0;
  logic [255:0] key_in = '0;
  logic         step_in = 1'b0;
  logic [5:0]   i_in = '0;
  logic [2:0]   imodk_in = '0;
  logic         last_in = 1'b0;
  logic [31:0]  sbox_word_out;
  logic [31:0]  sbox_word_in;
  logic [31:0]  word_out;
  logic [5:0]   word_idx_out;
  logic         word_valid_out;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx_out;
  logic         rk_valid_out;
  logic         done_out;
  logic         err_out;

  key_exp_word #(.KEY_W(256), .IDX_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .conf_in(conf_in), .load_in(load_in),
    .key_in(key_in), .step_in(step_in), .i_in(i_in), .imodk_in(imodk_in),
    .last_in(last_in), .sbox_word_out(sbox_word_out), .sbox_word_in(sbox_word_in),
    .word_out(word_out), .word_idx_out(word_idx_out), .word_valid_out(word_valid_out),
    .rk_out(rk_out), .rk_idx_out(rk_idx_out), .rk_valid_out(rk_valid_out),
    .done_out(done_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- AES primitives, derived from GF(2^8) arithmetic ----------------
  logic [7:0] sbox [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  // External S-box, combinational
  always_comb sbox_word_in = {sbox[sbox_word_out[31:24]], sbox[sbox_word_out[23:16]],
                              sbox[sbox_word_out[15:8]],  sbox[sbox_word_out[7:0]]};

  // ---------------- Reference model: whole schedule computed at load ----------------
  logic [31:0] mw [60];

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] tw;
    for (int k = 0; k < nk; k++) mw[k] = key[255-32*k -: 32];
    for (int k = nk; k < 4*nk + 28; k++) begin
      tw = mw[k-1];
      if (k % nk == 0) tw = subw({tw[23:0], tw[31:24]}) ^ {rcon_tab[k/nk - 1], 24'h0};
      else if (nk == 8 && k % nk == 4) tw = subw(tw);
      mw[k] = mw[k-nk] ^ tw;
    end
  endtask

  bit m_run = 0, m_err = 0, m_rk1 = 0;
  int m_nk = 4, m_next = 0;

  // Expected outputs after the next edge (n_*) and for the current cycle (e_*)
  bit           n_zero = 1, n_wv = 0, n_done = 0, n_rkv = 0, n_err = 0;
  logic [31:0]  n_w = '0;
  logic [5:0]   n_widx = '0;
  logic [127:0] n_rk = '0;
  logic [3:0]   n_rkidx = '0;
  bit           e_zero, e_wv, e_done, e_rkv, e_err;
  logic [31:0]  e_w;
  logic [5:0]   e_widx;
  logic [127:0] e_rk;
  logic [3:0]   e_rkidx;

  task automatic predict();
    int i;
    i = int'(i_in);
    n_wv = 0; n_done = 0; n_rkv = 0; n_zero = 0;
    if (rst_in) begin
      m_run = 0; m_err = 0; m_rk1 = 0; n_zero = 1;
    end else if (load_in) begin
      m_nk = (conf_in == 2'd1) ? 6 : (conf_in == 2'd2) ? 8 : 4;
      expand(key_in, m_nk);
      m_run = 1; m_next = m_nk; m_err = 0; m_rk1 = (m_nk == 8);
      n_rkv = 1; n_rk = {mw[0], mw[1], mw[2], mw[3]}; n_rkidx = 0;
    end else begin
      if (m_rk1) begin
        n_rkv = 1; n_rk = {mw[4], mw[5], mw[6], mw[7]}; n_rkidx = 1; m_rk1 = 0;
      end
      if (step_in) begin
        if (!m_run || i != m_next || int'(imodk_in) != m_next % m_nk) m_err = 1;
        else begin
          n_wv = 1; n_w = mw[i]; n_widx = 6'(i);
          if (i % 4 == 3) begin
            n_rkv = 1; n_rk = {mw[i-3], mw[i-2], mw[i-1], mw[i]}; n_rkidx = 4'(i / 4);
          end
          m_next++;
          if (last_in) begin
            n_done = 1; m_run = 0;
            if (i != 4*m_nk + 27) m_err = 1;
          end
        end
      end
    end
    n_err = m_err;
  endtask

  task automatic tick();
    predict();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  // ---------------- Per-cycle compare against the model ----------------
  logic [31:0]  dut_w [64];
  logic [127:0] dut_rk [16];
  logic [15:0]  rk_seen;
  int           rk_cnt;
  logic [5:0]   done_idx;

  task automatic clear_capture();
    for (int k = 0; k < 64; k++) dut_w[k] = '0;
    for (int k = 0; k < 16; k++) dut_rk[k] = '0;
    rk_seen = '0; rk_cnt = 0; done_idx = '0;
  endtask

  initial forever begin
    @(posedge clk_in);
    e_zero = n_zero; e_wv = n_wv; e_done = n_done; e_rkv = n_rkv; e_err = n_err;
    e_w = n_w; e_widx = n_widx; e_rk = n_rk; e_rkidx = n_rkidx;
    @(negedge clk_in);
    check("err_out", err_out, e_err);
    check("word_valid_out", word_valid_out, e_wv);
    check("done_out", done_out, e_done);
    check("rk_valid_out", rk_valid_out, e_rkv);
    if (e_wv) begin
      check("word_out", word_out, e_w);
      check("word_idx_out", word_idx_out, e_widx);
    end
    if (e_rkv) begin
      check("rk_out", rk_out, e_rk);
      check("rk_idx_out", rk_idx_out, e_rkidx);
    end
    if (e_zero) begin
      check("rst_word_out", word_out, 0);
      check("rst_word_idx_out", word_idx_out, 0);
      check("rst_rk_out", rk_out, 0);
      check("rst_rk_idx_out", rk_idx_out, 0);
      check("rst_sbox_word_out", sbox_word_out, 0);
    end
    if (word_valid_out) dut_w[word_idx_out] = word_out;
    if (rk_valid_out) begin
      dut_rk[rk_idx_out] = rk_out; rk_seen[rk_idx_out] = 1'b1; rk_cnt++;
    end
    if (done_out) done_idx = word_idx_out;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic idle(input int n);
    step_in = 0; load_in = 0; last_in = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [255:0] key, input logic [1:0] conf);
    key_in = key; conf_in = conf; load_in = 1;
    tick();
    load_in = 0;
  endtask

  task automatic run_steps(input int nk, input int first, input int count,
                           input int last_at, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      step_in = 1; i_in = 6'(i); imodk_in = 3'(i % nk); last_in = (i == last_at);
      tick();
      step_in = 0; last_in = 0;
    end
  endtask

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] rkey;
    int nk, i, lastidx, p;
    logic [1:0] conf;

    build_sbox();
    clear_capture();
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    idle(1);
    check("reset_err_out", err_out, 0);
    check("reset_word_valid_out", word_valid_out, 0);

    // AES-128 known answer
    clear_capture();
    do_load(KEY128, 2'd0);
    run_steps(4, 4, 40, 43, 0);
    idle(1);
    check("model_w4_128", mw[4], 32'ha0fafe17);
    check("model_w43_128", mw[43], 32'hb6630ca6);
    check("w4_128", dut_w[4], 32'ha0fafe17);
    check("w43_128", dut_w[43], 32'hb6630ca6);
    check("rk10_128", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("done_idx_128", done_idx, 6'd43);
    check("err_128", err_out, 0);
    check("rk_count_128", rk_cnt, 11);

    // AES-192 known answer
    clear_capture();
    do_load(KEY192, 2'd1);
    run_steps(6, 6, 46, 51, 1);
    idle(1);
    check("model_w6_192", mw[6], 32'hfe0c91f7);
    check("w6_192", dut_w[6], 32'hfe0c91f7);
    check("w51_192", dut_w[51], 32'h01002202);
    check("rk_count_192", rk_cnt, 13);
    check("rk_seen_192", rk_seen, 16'h1fff);
    check("done_idx_192", done_idx, 6'd51);

    // AES-256 known answer
    clear_capture();
    do_load(KEY256, 2'd2);
    run_steps(8, 8, 52, 59, 0);
    idle(1);
    check("model_w8_256", mw[8], 32'h9ba35411);
    check("w8_256", dut_w[8], 32'h9ba35411);
    check("w12_256", dut_w[12], 32'ha8b09c1a);
    check("w59_256", dut_w[59], 32'h706c631e);
    check("rk_seen_256", rk_seen, 16'h7fff);

    // Wrong index is flagged and ignored, load clears the error
    clear_capture();
    do_load(KEY128, 2'd0);
    step_in = 1; i_in = 6'd5; imodk_in = 3'd1; last_in = 0;
    tick();
    step_in = 0;
    check("bad_idx_err", err_out, 1);
    check("bad_idx_no_word", word_valid_out, 0);
    do_load(KEY128, 2'd0);
    check("load_clears_err", err_out, 0);

    // Mid-run restart at i=20 with a new key
    clear_capture();
    do_load({$urandom, $urandom, $urandom, $urandom, 128'h0}, 2'd0);
    run_steps(4, 4, 16, 99, 0);
    do_load(KEY128, 2'd0);
    run_steps(4, 4, 1, 99, 0);
    check("restart_w4", word_out, 32'ha0fafe17);
    check("restart_idx", word_idx_out, 6'd4);
    run_steps(4, 5, 39, 43, 0);
    check("restart_done", done_out, 1);

    // Reset in the middle of a run, then a step from IDLE
    do_load(KEY128, 2'd0);
    run_steps(4, 4, 10, 99, 0);
    rst_in = 1;
    tick();
    rst_in = 0;
    check("midrst_word_valid", word_valid_out, 0);
    check("midrst_rk_out", rk_out, 0);
    run_steps(4, 14, 1, 99, 0);
    check("idle_step_err", err_out, 1);

    // Early last_in: error, but the run still terminates
    do_load(KEY128, 2'd0);
    run_steps(4, 4, 6, 9, 0);
    check("early_last_done", done_out, 1);
    check("early_last_err", err_out, 1);
    run_steps(4, 10, 1, 99, 0);
    check("after_early_last_no_word", word_valid_out, 0);

    // Randomized runs with gaps, bad steps and load/step collisions
    for (int r = 0; r < 30; r++) begin
      conf = 2'($urandom_range(0, 3));
      nk = (conf == 2'd1) ? 6 : (conf == 2'd2) ? 8 : 4;
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step_in = 1'($urandom_range(0, 1)); i_in = 6'($urandom); imodk_in = 3'($urandom);
      do_load(rkey, conf);
      step_in = 0;
      i = nk;
      lastidx = 4*nk + 27;
      while (i <= lastidx) begin
        idle($urandom_range(0, 2));
        p = $urandom_range(0, 19);
        step_in = 1; i_in = 6'(i); imodk_in = 3'(i % nk); last_in = (i == lastidx);
        if (p == 0) i_in = 6'(i + 1);
        else if (p == 1) imodk_in = 3'((i + 1) % nk);
        tick();
        step_in = 0; last_in = 0;
        if (p > 1) i++;
      end
      idle(1);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
